// File: rtl/rv3n_func_alu_pkg.sv
// Shared constants for the rv3n ALU: class/op codes, para bit positions and
// the packed view of the 8-bit para field.
package rv3n_func_alu_pkg;

   localparam logic [2:0] ALU_CLS_MISC = 3'b000;
   localparam logic [2:0] ALU_CLS_SUB  = 3'b001;
   localparam logic [2:0] ALU_CLS_SLL  = 3'b010;
   localparam logic [2:0] ALU_CLS_SRL  = 3'b011;
   localparam logic [2:0] ALU_CLS_SRA  = 3'b100;

   localparam logic [2:0] ALU_OP_ADD  = 3'd0;
   localparam logic [2:0] ALU_OP_SLT  = 3'd1;
   localparam logic [2:0] ALU_OP_SLTU = 3'd2;
   localparam logic [2:0] ALU_OP_XOR  = 3'd3;
   localparam logic [2:0] ALU_OP_OR   = 3'd4;
   localparam logic [2:0] ALU_OP_AND  = 3'd5;

   localparam int ALU_PARA_OP_LSB  = 0;
   localparam int ALU_PARA_CLS_LSB = 3;
   localparam int ALU_PARA_PC      = 6;
   localparam int ALU_PARA_WORD    = 7;

   // Field order mirrors the para bit positions above, MSB first.
   typedef struct packed {
      logic       word;
      logic       pc_sel;
      logic [2:0] cls;
      logic [2:0] op;
   } alu_para_t;

endpackage

// File: rtl/rv3n_func_alu_if.sv
// Issue-side request and writeback-side acknowledge bundle of the rv3n ALU.
interface rv3n_func_alu_if #(
   parameter int XLEN = 32
);
   logic            func_alu_req_valid;
   logic [7:0]      func_alu_req_para;
   logic [XLEN-1:0] func_alu_req_pc;
   logic [XLEN-1:0] func_alu_req_operand0;
   logic [XLEN-1:0] func_alu_req_operand1;
   logic            func_alu_ack_valid;
   logic [XLEN-1:0] func_alu_ack_data;
   logic            func_alu_ack_ready;
   logic            func_alu_ack_busy;

   modport master (
      output func_alu_req_valid, func_alu_req_para, func_alu_req_pc,
             func_alu_req_operand0, func_alu_req_operand1, func_alu_ack_ready,
      input  func_alu_ack_valid, func_alu_ack_data, func_alu_ack_busy
   );

   modport slave (
      input  func_alu_req_valid, func_alu_req_para, func_alu_req_pc,
             func_alu_req_operand0, func_alu_req_operand1, func_alu_ack_ready,
      output func_alu_ack_valid, func_alu_ack_data, func_alu_ack_busy
   );

endinterface

// File: rtl/rv3n_func_alu_queue.sv
// In-order result queue: DEPTH entries, registered occupancy drives valid/full.
// Storage is not reset; only count and pointers are.
module rv3n_func_alu_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic [XLEN-1:0] data_i,
   input  logic            pop_i,
   output logic            valid_o,
   output logic [XLEN-1:0] head_o,
   output logic            full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign valid_o = (count_q != '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && valid_o;

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop)
         count_d = count_q + 1'b1;
      else if (do_pop && !do_push)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= data_i;
   end

   // Empty queue presents zero so consumers never see a stale entry.
   assign head_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/rv3n_func_alu.sv
// rv3n integer ALU: combinational op datapath feeding a registered result queue.
// Define RV3N_FUNC_ALU_WORD_EN to enable RV64 word ops (para[7]) when XLEN=64.
module rv3n_func_alu
   import rv3n_func_alu_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 2,
   localparam int SHW   = $clog2(XLEN)
) (
   input logic             clk,
   input logic             rst,
   rv3n_func_alu_if.slave  alu_if
);

`ifdef RV3N_FUNC_ALU_WORD_EN
   localparam logic WORD_EN = (XLEN == 64);
`else
   localparam logic WORD_EN = 1'b0;
`endif

   alu_para_t       para;
   logic [XLEN-1:0] result;
   logic            accept;
   logic            pop;

   function automatic logic [XLEN-1:0] alu_calc(
      input alu_para_t       p,
      input logic            word,
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      logic [XLEN-1:0] src0;
      logic [XLEN-1:0] full;
      logic [31:0]     w;
      logic [SHW-1:0]  sh;
      logic [4:0]      shw;
      logic            word_cls;
      src0     = p.pc_sel ? pc : a;
      sh       = b[SHW-1:0];
      shw      = b[4:0];
      full     = '0;
      w        = '0;
      word_cls = 1'b0;
      case (p.cls)
         ALU_CLS_MISC: begin
            case (p.op)
               ALU_OP_ADD: begin
                  full     = src0 + b;
                  w        = src0[31:0] + b[31:0];
                  word_cls = 1'b1;
               end
               ALU_OP_SLT:  full[0] = ($signed(a) < $signed(b));
               ALU_OP_SLTU: full[0] = (a < b);
               ALU_OP_XOR:  full    = a ^ b;
               ALU_OP_OR:   full    = a | b;
               ALU_OP_AND:  full    = a & b;
               default:     full    = '0;
            endcase
         end
         ALU_CLS_SUB: begin
            full     = a - b;
            w        = a[31:0] - b[31:0];
            word_cls = 1'b1;
         end
         ALU_CLS_SLL: begin
            full     = a << sh;
            w        = a[31:0] << shw;
            word_cls = 1'b1;
         end
         ALU_CLS_SRL: begin
            full     = a >> sh;
            w        = a[31:0] >> shw;
            word_cls = 1'b1;
         end
         ALU_CLS_SRA: begin
            full     = $signed(a) >>> sh;
            w        = $signed(a[31:0]) >>> shw;
            word_cls = 1'b1;
         end
         default: full = '0;
      endcase
      // Word results are the low 32 bits sign-extended to XLEN.
      return (word && word_cls) ? XLEN'($signed(w)) : full;
   endfunction

   assign para   = alu_para_t'(alu_if.func_alu_req_para);
   assign result = alu_calc(para, para.word & WORD_EN, alu_if.func_alu_req_pc,
                            alu_if.func_alu_req_operand0, alu_if.func_alu_req_operand1);

   // Busy depends only on registered occupancy, so a full queue blocks a push
   // even in a cycle where the head is popped.
   assign accept = alu_if.func_alu_req_valid && !alu_if.func_alu_ack_busy && !rst;
   assign pop    = alu_if.func_alu_ack_valid && alu_if.func_alu_ack_ready;

   rv3n_func_alu_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .data_i  (result),
      .pop_i   (pop),
      .valid_o (alu_if.func_alu_ack_valid),
      .head_o  (alu_if.func_alu_ack_data),
      .full_o  (alu_if.func_alu_ack_busy)
   );

endmodule

// File: tb/tb_rv3n_func_alu.sv
// Directed bench for rv3n_func_alu: a 32-bit DEPTH=2 instance and a 64-bit
// instance for the word-op configuration.
module tb_rv3n_func_alu;

`ifdef RV3N_FUNC_ALU_WORD_EN
   localparam bit WEN = 1'b1;
`else
   localparam bit WEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rv3n_func_alu_if #(.XLEN(32)) bus32 ();
   rv3n_func_alu_if #(.XLEN(64)) bus64 ();

   rv3n_func_alu #(.XLEN(32), .DEPTH(2)) dut32 (
      .clk    (clk),
      .rst    (rst),
      .alu_if (bus32)
   );

   rv3n_func_alu #(.XLEN(64), .DEPTH(2)) dut64 (
      .clk    (clk),
      .rst    (rst),
      .alu_if (bus64)
   );

   typedef struct packed {
      logic [7:0]  para;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec32_t;

   typedef struct packed {
      logic [7:0]  para;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec64_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req32(input logic v, input logic [7:0] para,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
      bus32.func_alu_req_valid    = v;
      bus32.func_alu_req_para     = para;
      bus32.func_alu_req_pc       = pc;
      bus32.func_alu_req_operand0 = a;
      bus32.func_alu_req_operand1 = b;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req32(1'b1, 8'h00, 32'h0, 32'd1, 32'd1);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b want 0", bus32.func_alu_ack_valid);
      end
      n_cmp++;
      if (bus32.func_alu_ack_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h want 00000000", bus32.func_alu_ack_data);
      end
      n_cmp++;
      if (bus32.func_alu_ack_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", bus32.func_alu_ack_busy);
      end
      n_cmp++;
      if (bus64.func_alu_ack_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid64: got %b want 0", bus64.func_alu_ack_valid);
      end
      rst = 1'b0;
      req32(1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_accept: got valid %b want 0", bus32.func_alu_ack_valid);
      end
   endtask

   task automatic test_basic_add();
      bus32.func_alu_ack_ready = 1'b1;
      req32(1'b1, 8'h00, 32'h0, 32'd5, 32'd7);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b1 || bus32.func_alu_ack_data !== 32'd12) begin
         n_fail++; $display("FAIL add_result: got valid %b data %h want 1 0000000c",
                            bus32.func_alu_ack_valid, bus32.func_alu_ack_data);
      end
      req32(1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b0 || bus32.func_alu_ack_data !== 32'h0) begin
         n_fail++; $display("FAIL add_drain: got valid %b data %h want 0 00000000",
                            bus32.func_alu_ack_valid, bus32.func_alu_ack_data);
      end
   endtask

   task automatic test_ops();
      vec32_t v[14];
      v[0]  = '{8'h00, 32'h0,    32'd5,        32'd7,        32'd12};
      v[1]  = '{8'h20, 32'h0,    32'h80000000, 32'h00000024, 32'hF8000000};
      v[2]  = '{8'h18, 32'h0,    32'h80000000, 32'h00000024, 32'h08000000};
      v[3]  = '{8'h10, 32'h0,    32'h00000001, 32'h00000024, 32'h00000010};
      v[4]  = '{8'h01, 32'h0,    32'hFFFFFFFF, 32'h00000001, 32'h00000001};
      v[5]  = '{8'h02, 32'h0,    32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      v[6]  = '{8'h40, 32'h1000, 32'h0000DEAD, 32'h00000020, 32'h00001020};
      v[7]  = '{8'h08, 32'h0,    32'd5,        32'd7,        32'hFFFFFFFE};
      v[8]  = '{8'h03, 32'h0,    32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
      v[9]  = '{8'h04, 32'h0,    32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
      v[10] = '{8'h05, 32'h0,    32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
      v[11] = '{8'h06, 32'h0,    32'd5,        32'd7,        32'h00000000};
      v[12] = '{8'h28, 32'h0,    32'd5,        32'd7,        32'h00000000};
      v[13] = '{8'h80, 32'h0,    32'h7FFFFFFF, 32'h00000001, 32'h80000000};
      bus32.func_alu_ack_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         req32(1'b1, v[i].para, v[i].pc, v[i].a, v[i].b);
         tick();
         n_cmp++;
         if (bus32.func_alu_ack_valid !== 1'b1 || bus32.func_alu_ack_data !== v[i].exp) begin
            n_fail++; $display("FAIL op_vec%0d para %h: got valid %b data %h want 1 %h",
                               i, v[i].para, bus32.func_alu_ack_valid,
                               bus32.func_alu_ack_data, v[i].exp);
         end
      end
      req32(1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b0) begin
         n_fail++; $display("FAIL op_drain: got valid %b want 0", bus32.func_alu_ack_valid);
      end
   endtask

   task automatic test_backpressure();
      bus32.func_alu_ack_ready = 1'b0;
      req32(1'b1, 8'h00, 32'h0, 32'd0, 32'd1);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_busy !== 1'b0 || bus32.func_alu_ack_data !== 32'd1) begin
         n_fail++; $display("FAIL bp_first: got busy %b data %h want 0 00000001",
                            bus32.func_alu_ack_busy, bus32.func_alu_ack_data);
      end
      req32(1'b1, 8'h00, 32'h0, 32'd0, 32'd2);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_busy !== 1'b1 || bus32.func_alu_ack_data !== 32'd1) begin
         n_fail++; $display("FAIL bp_full: got busy %b data %h want 1 00000001",
                            bus32.func_alu_ack_busy, bus32.func_alu_ack_data);
      end
      req32(1'b1, 8'h00, 32'h0, 32'd0, 32'd3);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_busy !== 1'b1 || bus32.func_alu_ack_data !== 32'd1) begin
         n_fail++; $display("FAIL bp_hold: got busy %b data %h want 1 00000001",
                            bus32.func_alu_ack_busy, bus32.func_alu_ack_data);
      end
      bus32.func_alu_ack_ready = 1'b1;
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_busy !== 1'b0 || bus32.func_alu_ack_valid !== 1'b1 ||
          bus32.func_alu_ack_data !== 32'd2) begin
         n_fail++; $display("FAIL bp_pop_when_full: got busy %b valid %b data %h want 0 1 00000002",
                            bus32.func_alu_ack_busy, bus32.func_alu_ack_valid,
                            bus32.func_alu_ack_data);
      end
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_busy !== 1'b0 || bus32.func_alu_ack_valid !== 1'b1 ||
          bus32.func_alu_ack_data !== 32'd3) begin
         n_fail++; $display("FAIL bp_push_pop_cnt1: got busy %b valid %b data %h want 0 1 00000003",
                            bus32.func_alu_ack_busy, bus32.func_alu_ack_valid,
                            bus32.func_alu_ack_data);
      end
      req32(1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b0 || bus32.func_alu_ack_data !== 32'h0) begin
         n_fail++; $display("FAIL bp_empty: got valid %b data %h want 0 00000000",
                            bus32.func_alu_ack_valid, bus32.func_alu_ack_data);
      end
   endtask

   task automatic test_reset_mid();
      bus32.func_alu_ack_ready = 1'b0;
      req32(1'b1, 8'h00, 32'h0, 32'd10, 32'd0);
      tick();
      req32(1'b1, 8'h00, 32'h0, 32'd20, 32'd0);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_busy !== 1'b1) begin
         n_fail++; $display("FAIL rm_full: got busy %b want 1", bus32.func_alu_ack_busy);
      end
      rst = 1'b1;
      req32(1'b1, 8'h00, 32'h0, 32'd99, 32'd0);
      tick();
      rst = 1'b0;
      req32(1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b0 || bus32.func_alu_ack_busy !== 1'b0 ||
          bus32.func_alu_ack_data !== 32'h0) begin
         n_fail++; $display("FAIL rm_cleared: got valid %b busy %b data %h want 0 0 00000000",
                            bus32.func_alu_ack_valid, bus32.func_alu_ack_busy,
                            bus32.func_alu_ack_data);
      end
      bus32.func_alu_ack_ready = 1'b1;
      req32(1'b1, 8'h00, 32'h0, 32'd3, 32'd4);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b1 || bus32.func_alu_ack_data !== 32'd7) begin
         n_fail++; $display("FAIL rm_after: got valid %b data %h want 1 00000007",
                            bus32.func_alu_ack_valid, bus32.func_alu_ack_data);
      end
      req32(1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
      tick();
      n_cmp++;
      if (bus32.func_alu_ack_valid !== 1'b0) begin
         n_fail++; $display("FAIL rm_drain: got valid %b want 0", bus32.func_alu_ack_valid);
      end
   endtask

   task automatic test_word_ops();
      vec64_t v[8];
      v[0] = '{8'h80, 64'h000000007FFFFFFF, 64'h1,
               WEN ? 64'hFFFFFFFF80000000 : 64'h0000000080000000};
      v[1] = '{8'h00, 64'h000000007FFFFFFF, 64'h1, 64'h0000000080000000};
      v[2] = '{8'h90, 64'h1, 64'h3F,
               WEN ? 64'hFFFFFFFF80000000 : 64'h8000000000000000};
      v[3] = '{8'h98, 64'hFFFFFFFFFFFFFFF0, 64'h4,
               WEN ? 64'h000000000FFFFFFF : 64'h0FFFFFFFFFFFFFFF};
      v[4] = '{8'hA0, 64'h0000000080000000, 64'h4,
               WEN ? 64'hFFFFFFFFF8000000 : 64'h0000000008000000};
      v[5] = '{8'h88, 64'h0000000100000000, 64'h1,
               WEN ? 64'hFFFFFFFFFFFFFFFF : 64'h00000000FFFFFFFF};
      v[6] = '{8'h82, 64'h1, 64'h0000000100000000, 64'h1};
      v[7] = '{8'h83, 64'hFFFFFFFF00000000, 64'h0, 64'hFFFFFFFF00000000};
      bus64.func_alu_ack_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus64.func_alu_req_valid    = 1'b1;
         bus64.func_alu_req_para     = v[i].para;
         bus64.func_alu_req_pc       = 64'h0;
         bus64.func_alu_req_operand0 = v[i].a;
         bus64.func_alu_req_operand1 = v[i].b;
         tick();
         n_cmp++;
         if (bus64.func_alu_ack_valid !== 1'b1 || bus64.func_alu_ack_data !== v[i].exp) begin
            n_fail++; $display("FAIL word_vec%0d para %h: got valid %b data %h want 1 %h",
                               i, v[i].para, bus64.func_alu_ack_valid,
                               bus64.func_alu_ack_data, v[i].exp);
         end
      end
      bus64.func_alu_req_valid = 1'b0;
      tick();
      n_cmp++;
      if (bus64.func_alu_ack_valid !== 1'b0 || bus64.func_alu_ack_data !== 64'h0) begin
         n_fail++; $display("FAIL word_drain: got valid %b data %h want 0 0",
                            bus64.func_alu_ack_valid, bus64.func_alu_ack_data);
      end
   endtask

   initial begin
      bus32.func_alu_ack_ready    = 1'b1;
      bus64.func_alu_ack_ready    = 1'b1;
      bus64.func_alu_req_valid    = 1'b0;
      bus64.func_alu_req_para     = 8'h0;
      bus64.func_alu_req_pc       = 64'h0;
      bus64.func_alu_req_operand0 = 64'h0;
      bus64.func_alu_req_operand1 = 64'h0;
      req32(1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
      #2;
      test_reset();
      test_basic_add();
      test_ops();
      test_backpressure();
      test_reset_mid();
      test_word_ops();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
